// File: rtl/e203_irq_stim_gen.sv
// e203_irq_stim_gen: interrupt stimulus generator for one e203 IRQ line.
// Once the program commits the post-mtvec setup PC it repeatedly waits a
// pseudo-random delay, raises irq_o and holds it until the handler's pre-mret
// PC commits. It stops after STOP_CNT acknowledged IRQs or an external stop.
// Optional ack timeout: define E203_IRQ_STIM_TIMEOUT_EN.
module e203_irq_stim_gen #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] ARM_PC   = 32'h8000015C,
  parameter logic [PC_W-1:0] ACK_PC   = 32'h800000A6,
  parameter int unsigned     MIN_DLY  = 1,
  parameter logic [15:0]     DLY_MASK = 16'h03FF,
  parameter logic [15:0]     SEED     = 16'hACE1,
  parameter int unsigned     STOP_CNT = 32,
  parameter int unsigned     TO_CYC   = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            cmt_valid,
  input  logic [PC_W-1:0] cmt_pc,
  input  logic            stop_i,
  output logic            irq_o,
  output logic [31:0]     irq_cnt_o,
  output logic [1:0]      state_o,
  output logic            timeout_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDelay  = 2'd1,
    StAssert = 2'd2,
    StDone   = 2'd3
  } state_e;

  // A zero seed would lock the LFSR at zero.
  localparam logic [15:0] LfsrInit = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [16:0] MinDly17 = 17'(MIN_DLY);
  localparam logic [32:0] StopCnt33 = 33'(STOP_CNT);

  // Elaboration-time parameter sanity checks.
  if (MIN_DLY < 1) begin : g_chk_min_dly
    $error("MIN_DLY must be at least 1");
  end
  if (TO_CYC < 1) begin : g_chk_to_cyc
    $error("TO_CYC must be at least 1");
  end

  state_e      r_state;
  logic        r_irq;
  logic [31:0] r_irq_cnt;
  logic [16:0] r_dly_cnt;
  logic [15:0] r_lfsr;

  logic        w_arm_hit;
  logic        w_ack_hit;
  logic [15:0] w_lfsr_nxt;
  logic [16:0] w_dly_load;
  logic [31:0] w_cnt_inc;
  logic        w_stop_now;

  assign w_arm_hit  = cmt_valid & (cmt_pc == ARM_PC);
  assign w_ack_hit  = cmt_valid & (cmt_pc == ACK_PC);
  // Galois right-shift form, taps 16'hB400 (maximal length).
  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_dly_load = MinDly17 + {1'b0, r_lfsr & DLY_MASK};
  assign w_cnt_inc  = (&r_irq_cnt) ? r_irq_cnt : r_irq_cnt + 32'd1;
  // Stop test uses the pre-increment count plus one, evaluated in 33 bits.
  assign w_stop_now = stop_i | (({1'b0, r_irq_cnt} + 33'd1) >= StopCnt33);

`ifdef E203_IRQ_STIM_TIMEOUT_EN
  localparam logic [31:0] ToLast = 32'(TO_CYC - 1);
  logic [31:0] r_to_cnt;
  logic        r_timeout;
`endif

  // Delay randomiser: free-runs while enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr <= LfsrInit;
    end else if (en) begin
      r_lfsr <= w_lfsr_nxt;
    end
  end

  // Main FSM with registered IRQ, ack counter and delay counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_irq     <= 1'b0;
      r_irq_cnt <= 32'd0;
      r_dly_cnt <= 17'd0;
`ifdef E203_IRQ_STIM_TIMEOUT_EN
      r_to_cnt  <= 32'd0;
      r_timeout <= 1'b0;
`endif
    end else if (!en) begin
      // Counters and sticky flags survive a disable.
      r_state <= StIdle;
      r_irq   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_irq <= 1'b0;
          if (w_arm_hit) begin
            r_state   <= StDelay;
            r_dly_cnt <= w_dly_load;
          end
        end
        StDelay: begin
          if (stop_i) begin
            r_state <= StDone;
            r_irq   <= 1'b0;
          end else if (r_dly_cnt <= 17'd1) begin
            r_state <= StAssert;
            r_irq   <= 1'b1;
`ifdef E203_IRQ_STIM_TIMEOUT_EN
            r_to_cnt <= 32'd0;
`endif
          end else begin
            r_dly_cnt <= r_dly_cnt - 17'd1;
          end
        end
        StAssert: begin
          // A pending handler always completes; stop only takes effect at ack.
          if (w_ack_hit) begin
            r_irq     <= 1'b0;
            r_irq_cnt <= w_cnt_inc;
            if (w_stop_now) begin
              r_state <= StDone;
            end else begin
              r_state   <= StDelay;
              r_dly_cnt <= w_dly_load;
            end
`ifdef E203_IRQ_STIM_TIMEOUT_EN
          end else if (r_to_cnt == ToLast) begin
            r_timeout <= 1'b1;
            r_irq     <= 1'b0;
            r_state   <= StDone;
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
`endif
          end
        end
        StDone: begin
          r_irq <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_o     = r_irq;
  assign irq_cnt_o = r_irq_cnt;
  assign state_o   = r_state;

`ifdef E203_IRQ_STIM_TIMEOUT_EN
  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

endmodule
